// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit register port between NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to force-release packet locks whose owner stalls for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter logic [31:0] BAUD_DIV     = 32'h1B8,
  parameter logic [31:0] UART_BASE    = 32'h0,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   uart_we_o,
  output logic [31:0]            uart_addr_o,
  output logic [31:0]            uart_data_o,
  input  logic [31:0]            uart_data_i,
  output logic                   init_done_o,
  output logic                   busy_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [31:0] ADDR_CTRL   = UART_BASE + 32'h0;
  localparam logic [31:0] ADDR_STATUS = UART_BASE + 32'h4;
  localparam logic [31:0] ADDR_BAUD   = UART_BASE + 32'h8;
  localparam logic [31:0] ADDR_TXDATA = UART_BASE + 32'hC;

  localparam logic [2:0] ST_INIT_BAUD = 3'd0;
  localparam logic [2:0] ST_INIT_CTRL = 3'd1;
  localparam logic [2:0] ST_ARB       = 3'd2;
  localparam logic [2:0] ST_POLL      = 3'd3;
  localparam logic [2:0] ST_WRITE     = 3'd4;

  if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  logic [2:0]         r_state;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic               r_init_done;
  logic               r_lock;
  logic [PW-1:0]      r_owner;
  logic [PW-1:0]      r_ptr;
  logic [7:0]         r_hold;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]        r_to_cnt;
`endif

  logic               w_gnt_vld;
  logic [PW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [7:0]         w_gnt_data;
  logic               w_gnt_last;
  int                 w_scan;
  logic               w_unused;

  assign w_unused = ^uart_data_i[31:1];

  // A held lock restricts eligibility to its owner; otherwise scan from r_ptr+1 with wrap.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_scan     = 0;
    if (r_lock) begin
      w_gnt_vld = req_valid_i[r_owner];
      w_gnt_idx = r_owner;
    end else begin
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
        w_scan = int'(r_ptr) + i;
        if (w_scan >= int'(NUM_REQ)) w_scan = w_scan - int'(NUM_REQ);
        if (!w_gnt_vld && req_valid_i[w_scan]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PW'(w_scan);
        end
      end
    end
    w_gnt_data = req_data_i[int'(w_gnt_idx)*8 +: 8];
    w_gnt_last = req_last_i[w_gnt_idx];
  end

  assign w_gnt_oh = NUM_REQ'(1) << w_gnt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT_BAUD;
      r_ready     <= '0;
      r_we        <= 1'b0;
      r_addr      <= ADDR_STATUS;
      r_data      <= 32'h0;
      r_init_done <= 1'b0;
      r_lock      <= 1'b0;
      r_owner     <= '0;
      r_ptr       <= PW'(NUM_REQ - 1);
      r_hold      <= 8'h0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt    <= 16'h0;
`endif
    end else begin
      r_ready <= '0;
      r_we    <= 1'b0;
      r_addr  <= ADDR_STATUS;
      r_data  <= 32'h0;
      case (r_state)
        ST_INIT_BAUD: begin
          r_we    <= 1'b1;
          r_addr  <= ADDR_BAUD;
          r_data  <= BAUD_DIV;
          r_state <= ST_INIT_CTRL;
        end
        ST_INIT_CTRL: begin
          // tx enable only; rx enable and the ID-send bit stay clear
          r_we        <= 1'b1;
          r_addr      <= ADDR_CTRL;
          r_data      <= 32'h1;
          r_init_done <= 1'b1;
          r_state     <= ST_ARB;
        end
        ST_ARB: begin
          if (w_gnt_vld) begin
            r_ready <= w_gnt_oh;
            r_hold  <= w_gnt_data;
            r_state <= ST_POLL;
            if (w_gnt_last) begin
              r_lock <= 1'b0;
              r_ptr  <= w_gnt_idx;
            end else begin
              r_lock  <= 1'b1;
              r_owner <= w_gnt_idx;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          if (w_gnt_vld) begin
            r_to_cnt <= 16'h0;
          end else if (r_lock) begin
            if (r_to_cnt == 16'(LOCK_TIMEOUT - 1)) begin
              r_lock   <= 1'b0;
              r_ptr    <= r_owner;
              r_to_cnt <= 16'h0;
            end else begin
              r_to_cnt <= r_to_cnt + 16'h1;
            end
          end
`endif
        end
        ST_POLL: begin
          if (!uart_data_i[0]) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_we    <= 1'b1;
          r_addr  <= ADDR_TXDATA;
          r_data  <= {24'h0, r_hold};
          r_state <= ST_ARB;
        end
        default: r_state <= ST_INIT_BAUD;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign uart_we_o   = r_we;
  assign uart_addr_o = r_addr;
  assign uart_data_o = r_data;
  assign init_done_o = r_init_done;
  assign busy_o      = (r_state == ST_POLL) || (r_state == ST_WRITE) || r_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: init sequence, latency, UART busy wait, round robin and packet locks.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0]  d0 = 8'h0, d1 = 8'h0;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic        uart_we, init_done, busy;
  logic [31:0] uart_addr, uart_wdata, uart_rdata;

  int vectors = 0, miscompares = 0;
  int busy_len = 0, busy_cnt = 0, cyc = 0, to_cnt = 0;
  int multi = 0, wr_busy = 0, acc_busy = 0;
  int rdy_cyc[2];
  logic [1:0] seen_rdy;
  logic [7:0] wq[$];
  int wc[$];
  int gq[$];

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  uart_tx_arbiter #(.NUM_REQ(2), .BAUD_DIV(32'h1B8), .UART_BASE(32'h0), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last), .req_ready_o(req_ready),
    .uart_we_o(uart_we), .uart_addr_o(uart_addr), .uart_data_o(uart_wdata), .uart_data_i(uart_rdata),
    .init_done_o(init_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // UART model: tx busy for busy_len cycles after each TXDATA write
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) busy_cnt <= 0;
    else if (uart_we && uart_addr == 32'hC) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always_comb begin
    uart_rdata = 32'h0;
    if (uart_addr == 32'h4) uart_rdata = {31'h0, busy_cnt != 0};
  end

  always @(negedge clk) begin
    if (rst) begin
      wq.delete(); wc.delete(); gq.delete();
      multi = 0; wr_busy = 0; acc_busy = 0;
    end else begin
      if (uart_we && uart_addr == 32'hC) begin
        wq.push_back(uart_wdata[7:0]);
        wc.push_back(cyc);
        if (busy_cnt != 0) wr_busy++;
      end
      if (req_ready != 2'b00) begin
        if ($countones(req_ready) != 1) multi++;
        gq.push_back(req_ready[1] ? 1 : 0);
        rdy_cyc[req_ready[1] ? 1 : 0] = cyc;
        if (busy_cnt != 0) acc_busy++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic last);
    int n;
    if (k == 0) begin v0 = 1'b1; d0 = d; l0 = last; end
    else begin v1 = 1'b1; d1 = d; l1 = last; end
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[k] && n < 300);
    if (!req_ready[k]) to_cnt++;
    seen_rdy = req_ready;
    if (k == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (wq.size() < n && t < 300) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (uart_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", uart_we); end
    vectors++; if (uart_addr !== 32'h4) begin miscompares++; $display("FAIL reset_addr: got %h want 4", uart_addr); end
    vectors++; if (uart_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", uart_wdata); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", init_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if ({uart_we, uart_addr, uart_wdata} !== {1'b1, 32'h8, 32'h1B8}) begin
      miscompares++; $display("FAIL init_baud: got we=%b addr=%h data=%h want 1/8/1b8", uart_we, uart_addr, uart_wdata); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL init_done_early: got %b want 0", init_done); end
    @(negedge clk);
    vectors++; if ({uart_we, uart_addr, uart_wdata} !== {1'b1, 32'h0, 32'h1}) begin
      miscompares++; $display("FAIL init_ctrl: got we=%b addr=%h data=%h want 1/0/1", uart_we, uart_addr, uart_wdata); end
    @(negedge clk);
    vectors++; if ({uart_we, uart_addr, uart_wdata} !== {1'b0, 32'h4, 32'h0}) begin
      miscompares++; $display("FAIL idle_bus: got we=%b addr=%h data=%h want 0/4/0", uart_we, uart_addr, uart_wdata); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL init_done: got %b want 1", init_done); end
  endtask

  task automatic test_single_byte();
    do_reset();
    busy_len = 0;
    send_byte(0, 8'h41, 1'b1);
    vectors++; if (seen_rdy !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b want 01", seen_rdy); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_poll: got %b want 1", busy); end
    @(negedge clk);
    vectors++; if ({req_ready, uart_we} !== 3'b000) begin
      miscompares++; $display("FAIL single_n1: got ready=%b we=%b want 00/0", req_ready, uart_we); end
    @(negedge clk);
    vectors++; if ({uart_we, uart_addr, uart_wdata} !== {1'b1, 32'hC, 32'h41}) begin
      miscompares++; $display("FAIL single_write: got we=%b addr=%h data=%h want 1/c/41", uart_we, uart_addr, uart_wdata); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done: got %b want 0", busy); end
    repeat (5) @(negedge clk);
    vectors++; if (wq.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", wq.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    busy_len = 20;
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'hAA, 1'b1);
    wait_writes(2);
    busy_len = 0;
    vectors++; if (wq.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", wq.size()); end
    else begin
      vectors++; if ({wq[0], wq[1]} !== 16'h55AA) begin
        miscompares++; $display("FAIL b2b_order: got %h %h want 55 aa", wq[0], wq[1]); end
      vectors++; if (wc[1] - wc[0] !== 23) begin
        miscompares++; $display("FAIL b2b_gap: got %0d want 23", wc[1] - wc[0]); end
    end
    vectors++; if (acc_busy !== 1) begin miscompares++; $display("FAIL b2b_accept_busy: got %0d want 1", acc_busy); end
    vectors++; if (wr_busy !== 0) begin miscompares++; $display("FAIL b2b_write_busy: got %0d want 0", wr_busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_w[4];
    int exp_g[4];
    exp_w = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_g = '{0, 1, 0, 1};
    do_reset();
    fork
      begin send_byte(0, 8'h10, 1'b1); send_byte(0, 8'h11, 1'b1); end
      begin send_byte(1, 8'h20, 1'b1); send_byte(1, 8'h21, 1'b1); end
    join
    wait_writes(4);
    vectors++; if (wq.size() !== 4) begin miscompares++; $display("FAIL rr_count: got %0d want 4", wq.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (wq[i] !== exp_w[i]) begin miscompares++; $display("FAIL rr_byte%0d: got %h want %h", i, wq[i], exp_w[i]); end
      vectors++; if (gq[i] !== exp_g[i]) begin miscompares++; $display("FAIL rr_grant%0d: got %0d want %0d", i, gq[i], exp_g[i]); end
    end
    vectors++; if (multi !== 0) begin miscompares++; $display("FAIL rr_onehot: got %0d want 0", multi); end
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp_w[4];
    int exp_g[4];
    exp_w = '{8'h01, 8'h02, 8'h03, 8'h7F};
    exp_g = '{0, 0, 0, 1};
    do_reset();
    fork
      begin send_byte(0, 8'h01, 1'b0); send_byte(0, 8'h02, 1'b0); send_byte(0, 8'h03, 1'b1); end
      send_byte(1, 8'h7F, 1'b1);
    join
    wait_writes(4);
    vectors++; if (wq.size() !== 4) begin miscompares++; $display("FAIL lock_count: got %0d want 4", wq.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (wq[i] !== exp_w[i]) begin miscompares++; $display("FAIL lock_byte%0d: got %h want %h", i, wq[i], exp_w[i]); end
      vectors++; if (gq[i] !== exp_g[i]) begin miscompares++; $display("FAIL lock_grant%0d: got %0d want %0d", i, gq[i], exp_g[i]); end
    end
    vectors++; if (multi !== 0) begin miscompares++; $display("FAIL lock_onehot: got %0d want 0", multi); end
    vectors++; if (to_cnt !== 0) begin miscompares++; $display("FAIL handshake_timeout: got %0d want 0", to_cnt); end
  endtask

  task automatic test_lock_stall();
    int t;
    do_reset();
    v1 = 1'b1; d1 = 8'h7F; l1 = 1'b1;
    send_byte(0, 8'h01, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    t = 0;
    while (gq.size() < 2 && t < 100) begin @(negedge clk); t++; end
    v1 = 1'b0;
    vectors++; if (gq.size() !== 2) begin miscompares++; $display("FAIL timeout_release: got %0d grants want 2", gq.size()); end
    else begin
      vectors++; if (rdy_cyc[1] - rdy_cyc[0] !== 11) begin
        miscompares++; $display("FAIL timeout_delay: got %0d want 11", rdy_cyc[1] - rdy_cyc[0]); end
    end
    wait_writes(2);
    vectors++; if (wq.size() !== 2 || wq[1] !== 8'h7F) begin
      miscompares++; $display("FAIL timeout_write: got %0d writes want 2 ending 7f", wq.size()); end
`else
    t = 0;
    repeat (60) begin @(negedge clk); t++; end
    vectors++; if (gq.size() !== 1) begin miscompares++; $display("FAIL stall_grants: got %0d want 1", gq.size()); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b want 1", busy); end
    vectors++; if (wq.size() !== 1) begin miscompares++; $display("FAIL stall_writes: got %0d want 1", wq.size()); end
`endif
    // reset while a lock may be held must drop it and redo init
    rst = 1'b1; v1 = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, uart_we, init_done} !== 3'b000) begin
      miscompares++; $display("FAIL midreset: got busy=%b we=%b done=%b want 000", busy, uart_we, init_done); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if ({uart_we, uart_addr} !== {1'b1, 32'h8}) begin
      miscompares++; $display("FAIL midreset_reinit: got we=%b addr=%h want 1/8", uart_we, uart_addr); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_round_robin();
    test_packet_lock();
    test_lock_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
